sseg_bcd_display: RTL
=====================

// Module: sseg_bcd_display
// PURPOSE
//  Parametrised multi-digit decimal display driver for the 8-bit computer's output stage.
//  Captures a binary value on a write strobe and converts it to BCD with a sequential
//  shift-add-3 (double-dabble) engine, one bit per clock. Drives DIGITS active-low
//  seven-segment outputs with optional leading-zero blanking.
//  Sits between the output register write path and the board HEX displays.
// PARAMETERS
//  WIDTH   8  binary input width in bits (>=2)
//  DIGITS  3  number of 7-seg digits driven (>=1); digit 0 is the least significant
// PORTS
//  clk       in   1           clock; all state updates on rising edge
//  rst       in   1           asynchronous, active-high reset
//  value_in  in   WIDTH       value to display, sampled when wr=1
//  wr        in   1           write strobe, one-cycle pulse or level
//  blank_lz  in   1           1 = blank leading zeros (live input, applied combinationally)
//  busy      out  1           1 while a conversion is in progress
//  segments  out  8*DIGITS    digit n on [8n+7:8n]; bit7=DP, bits6:0=g..a, active-low
// BEHAVIOUR
//  - Reset: state IDLE, busy=0, pending flag=0, display BCD register=0.
//    segments = 8'hC0 on every digit, or only digit 0 = 8'hC0 and the rest 8'hFF when blank_lz=1.
//  - Encoding: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90;
//    blank=FF, minus=BF, overflow=7F (DP only).
//  - FSM IDLE -> SHIFT -> DONE -> IDLE; busy = (state != IDLE).
//  - IDLE: wr=1 at edge k latches value_in, clears BCD accumulator, bit counter=WIDTH, goes to SHIFT.
//  - SHIFT: each cycle, add 3 to any accumulator nibble >=5, then shift in the next binary MSB.
//    After exactly WIDTH cycles, go to DONE.
//  - DONE: copy the accumulator and overflow flag into the display register, go to IDLE.
//    segments change at edge k+WIDTH+1. busy is high from edge k to edge k+WIDTH+1.
//  - Display register holds its previous value throughout a conversion (no flicker).
//  - wr while busy:
//    - value_in is stored in a one-entry pending buffer; a later wr overwrites it (last write wins).
//    - In DONE with pending set, the FSM reloads from the buffer and returns to SHIFT the next cycle.
//      busy stays 1 and the pending flag clears.
//    - wr in the DONE cycle also counts as pending.
//  - Overflow: if the converted value > 10^D-1 (D = magnitude digits), every digit shows 7F.
//    Detected by any carry out of the top BCD nibble during shifting.
//  - Blanking: a digit is blank when blank_lz=1, it is not digit 0, and it and all more
//    significant digits are zero. Overflow overrides blanking.
//  - Reset mid-conversion aborts immediately: pending is dropped and the display returns
//    to its reset value.
// CONFIGURATION
//  SSEG_SIGNED_EN defined:
//  - value_in is two's complement. Magnitude = |value| in WIDTH-bit unsigned, so the most
//    negative value converts correctly.
//  - D = DIGITS-1.
//  - Negative: minus (BF) goes in the digit immediately left of the most significant shown
//    digit when blank_lz=1, otherwise in digit DIGITS-1.
//  - Positive: that sign position is blank (FF).
//  - Overflow: all digits 7F. Latency is unchanged.
//  SSEG_SIGNED_EN undefined: unsigned input, D = DIGITS, no sign logic is synthesised.
// TESTING
//  1. Assert and release rst -> segments={C0,C0,C0}, busy=0.
//  2. wr value 255 at edge k -> busy=1 for edges k..k+8; at k+9 segments={A4,92,92}, busy=0.
//  3. blank_lz=1, wr 7 -> {FF,FF,F8}; then wr 0 -> {FF,FF,C0} (digit 0 never blanked).
//  4. wr 100; wr 42 and wr 17 during busy -> shows {F9,C0,C0}, then {FF/C0,F9,F8} for 17.
//     42 is never displayed; busy stays high across both conversions.
//  5. WIDTH=10, DIGITS=3, wr 1000 -> {7F,7F,7F}; then wr 999 -> {90,90,90}.
//  6. SSEG_SIGNED_EN, DIGITS=4: wr -128 -> {BF,F9,A4,80}. wr -5 with blank_lz=1 -> {FF,FF,BF,92}.
//     rst asserted mid-conversion -> busy=0 and the display resets; pending is discarded.

Source files
------------

// File: rtl/sseg_bcd_display_if.sv
// Write/display bus between the output-register write path and the 7-segment driver.
interface sseg_bcd_display_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic [WIDTH-1:0]    value_in;
  logic                wr;
  logic                blank_lz;
  logic                busy;
  logic [8*DIGITS-1:0] segments;

  modport master (output value_in, wr, blank_lz, input busy, segments);
  modport slave  (input value_in, wr, blank_lz, output busy, segments);
endinterface

// File: rtl/sseg_bcd_display.sv
// Binary-to-BCD seven-segment driver: sequential double-dabble, one bit per clock.
// Define SSEG_SIGNED_EN for two's-complement input with a sign digit.
module sseg_bcd_display #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input logic               clk,
  input logic               rst,
  sseg_bcd_display_if.slave bus
);
`ifdef SSEG_SIGNED_EN
  localparam int D = DIGITS - 1;
`else
  localparam int D = DIGITS;
`endif
  localparam int BW = 4 * D;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_OVF   = 8'h7F;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] bin_q, pend_val_q, load_val, load_mag;
  logic [BW-1:0]    acc_q, acc_adj, disp_bcd_q;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q, disp_ovf_q, pend_q, load;
`ifdef SSEG_SIGNED_EN
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  logic             neg_q, disp_neg_q, load_neg;
`endif

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return SEG_BLANK;
    endcase
  endfunction

  // A DONE-cycle write bypasses the pending buffer since it is the newest value.
  always_comb begin
    load     = (state == IDLE && bus.wr) || (state == DONE && (bus.wr || pend_q));
    load_val = (state == DONE && !bus.wr) ? pend_val_q : bus.value_in;
`ifdef SSEG_SIGNED_EN
    load_neg = load_val[WIDTH-1];
    load_mag = load_neg ? (~load_val) + WIDTH'(1) : load_val;
`else
    load_mag = load_val;
`endif
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < D; i++)
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = load ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the data registers are reset too, so an aborted conversion leaves no stale pending value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      disp_bcd_q <= '0;
      disp_ovf_q <= 1'b0;
`ifdef SSEG_SIGNED_EN
      neg_q      <= 1'b0;
      disp_neg_q <= 1'b0;
`endif
    end else begin
      if (load) begin
        bin_q <= load_mag;
        acc_q <= '0;
        cnt_q <= CW'(WIDTH);
        ovf_q <= 1'b0;
`ifdef SSEG_SIGNED_EN
        neg_q <= load_neg;
`endif
      end else if (state == SHIFT) begin
        bin_q <= bin_q << 1;
        acc_q <= {acc_adj[BW-2:0], bin_q[WIDTH-1]};
        ovf_q <= ovf_q | acc_adj[BW-1];
        cnt_q <= cnt_q - CW'(1);
      end
      if (state == DONE) begin
        disp_bcd_q <= acc_q;
        disp_ovf_q <= ovf_q;
        pend_q     <= 1'b0;
`ifdef SSEG_SIGNED_EN
        disp_neg_q <= neg_q;
`endif
      end else if (state == SHIFT && bus.wr) begin
        pend_q     <= 1'b1;
        pend_val_q <= bus.value_in;
      end
    end
  end

  // Scan from the most significant digit; leading zeros stay blank while blank_lz is set.
  always_comb begin
    logic lead;
`ifdef SSEG_SIGNED_EN
    int msd;
    msd = 0;
`endif
    bus.busy     = (state != IDLE);
    bus.segments = '1;
    lead         = 1'b1;
    for (int n = D - 1; n >= 0; n--) begin
      if (lead && disp_bcd_q[4*n +: 4] != 4'd0) begin
        lead = 1'b0;
`ifdef SSEG_SIGNED_EN
        msd  = n;
`endif
      end
      if (!(bus.blank_lz && lead && n != 0))
        bus.segments[8*n +: 8] = seg_of(disp_bcd_q[4*n +: 4]);
    end
`ifdef SSEG_SIGNED_EN
    for (int n = 0; n < DIGITS; n++)
      if (n == (bus.blank_lz ? msd + 1 : DIGITS - 1))
        bus.segments[8*n +: 8] = disp_neg_q ? SEG_MINUS : SEG_BLANK;
`endif
    if (disp_ovf_q) bus.segments = {DIGITS{SEG_OVF}};
  end
endmodule
